// File: rtl/flex_dispatch_queue_pkg.sv
// Shared definitions for the dispatch queue slice.
//  - default physical-register and robIdx widths
//  - rob_idx_t: robIdx = {dir, idx}
//  - rob_older(): age compare between two robIdx values, idx widened so any
//    module width up to DQ_ROB_IDX_MAX bits can reuse it
package flex_dispatch_queue_pkg;

  localparam int unsigned DQ_PREG_WIDTH    = 7;
  localparam int unsigned DQ_ROB_IDX_WIDTH = 6;
  localparam int unsigned DQ_ROB_IDX_MAX   = 16;

  typedef struct packed {
    logic                        dir;
    logic [DQ_ROB_IDX_WIDTH-1:0] idx;
  } rob_idx_t;

  // True when a is older than or the same uop as b. The dir bit flips on every
  // ROB wrap, so with differing dir the smaller-looking idx is the younger one.
  function automatic logic rob_older(input logic                      a_dir,
                                     input logic [DQ_ROB_IDX_MAX-1:0] a_idx,
                                     input logic                      b_dir,
                                     input logic [DQ_ROB_IDX_MAX-1:0] b_idx);
    if (a_dir == b_dir) begin
      return a_idx <= b_idx;
    end
    return a_idx > b_idx;
  endfunction

endpackage

// File: rtl/flex_dispatch_queue_age_mask.sv
// dq_age_mask: counts how many live queue entries survive a redirect.
//  head             in  oldest entry slot
//  num              in  number of live entries, window is [head, head+num)
//  entry_rob_idx    in  robIdx of every slot, slot e at [e*(W+1) +: W+1]
//  redirect_rob_idx in  robIdx of the redirecting uop (it survives)
//  keep             out live entries that are older than or equal to it
module dq_age_mask
  import flex_dispatch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH         = 16,
  parameter  int unsigned ROB_IDX_WIDTH = DQ_ROB_IDX_WIDTH,
  localparam int unsigned ADDR_WIDTH    = $clog2(DEPTH),
  localparam int unsigned CNT_WIDTH     = $clog2(DEPTH + 1),
  localparam int unsigned ROB_W         = ROB_IDX_WIDTH + 1
) (
  input  logic [ADDR_WIDTH-1:0]  head,
  input  logic [CNT_WIDTH-1:0]   num,
  input  logic [DEPTH*ROB_W-1:0] entry_rob_idx,
  input  logic [ROB_W-1:0]       redirect_rob_idx,
  output logic [CNT_WIDTH-1:0]   keep
);

  logic [DEPTH-1:0] live;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [ADDR_WIDTH-1:0] rel;
    logic [ROB_W-1:0]      ent;
    // distance from head modulo DEPTH decides membership of the valid window
    assign rel = ADDR_WIDTH'(e) - head;
    assign ent = entry_rob_idx[e*ROB_W +: ROB_W];
    assign live[e] = ({1'b0, rel} < num) &&
                     rob_older(ent[ROB_IDX_WIDTH],
                               DQ_ROB_IDX_MAX'(ent[ROB_IDX_WIDTH-1:0]),
                               redirect_rob_idx[ROB_IDX_WIDTH],
                               DQ_ROB_IDX_MAX'(redirect_rob_idx[ROB_IDX_WIDTH-1:0]));
  end

  always_comb begin
    keep = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      keep = keep + CNT_WIDTH'(live[e]);
    end
  end

endmodule

// File: rtl/flex_dispatch_queue.sv
// flex_dispatch_queue: in-order circular dispatch queue between rename and issue.
//  clk, rst          clock, asynchronous active-low reset
//  in_en             per-lane enqueue valid, any sparse pattern, compacted on write
//  in_rs1/in_rs2     per-lane source pregs
//  in_robIdx/in_data per-lane robIdx {dir, idx} and payload
//  dis_full          global rename stall, blocks enqueue
//  full              occupancy plus requested lanes would exceed DEPTH
//  out_valid         thermometer, bit i set when more than i entries are held
//  out_*             fields of entry head+i
//  issue_num         entries the consumer takes this cycle (must not exceed count)
//  redirect*         squash every entry younger than redirect_robIdx
//  count             current occupancy
module flex_dispatch_queue
  import flex_dispatch_queue_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned DEPTH         = 16,
  parameter  int unsigned IN_WIDTH      = 4,
  parameter  int unsigned OUT_WIDTH     = 2,
  parameter  int unsigned PREG_WIDTH    = DQ_PREG_WIDTH,
  parameter  int unsigned ROB_IDX_WIDTH = DQ_ROB_IDX_WIDTH,
  parameter  int unsigned NEED_WALK     = 1,
  localparam int unsigned ADDR_WIDTH    = $clog2(DEPTH),
  localparam int unsigned CNT_WIDTH     = $clog2(DEPTH + 1),
  localparam int unsigned ISS_WIDTH     = $clog2(OUT_WIDTH + 1),
  localparam int unsigned ROB_W         = ROB_IDX_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_WIDTH-1:0]             in_en,
  input  logic [IN_WIDTH*PREG_WIDTH-1:0]  in_rs1,
  input  logic [IN_WIDTH*PREG_WIDTH-1:0]  in_rs2,
  input  logic [IN_WIDTH*ROB_W-1:0]       in_robIdx,
  input  logic [IN_WIDTH*DATA_WIDTH-1:0]  in_data,
  input  logic                            dis_full,
  output logic                            full,
  output logic [OUT_WIDTH-1:0]            out_valid,
  output logic [OUT_WIDTH*PREG_WIDTH-1:0] out_rs1,
  output logic [OUT_WIDTH*PREG_WIDTH-1:0] out_rs2,
  output logic [OUT_WIDTH*ROB_W-1:0]      out_robIdx,
  output logic [OUT_WIDTH*DATA_WIDTH-1:0] out_data,
  input  logic [ISS_WIDTH-1:0]            issue_num,
  input  logic                            redirect,
  input  logic [ROB_W-1:0]                redirect_robIdx,
  output logic [CNT_WIDTH-1:0]            count
);

  // payload storage, never reset: validity comes only from num_q
  logic [PREG_WIDTH-1:0] rs1_mem_q  [DEPTH];
  logic [PREG_WIDTH-1:0] rs2_mem_q  [DEPTH];
  logic [ROB_W-1:0]      rob_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  num_q,  num_d;

  logic [ADDR_WIDTH-1:0] lane_off [IN_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_addr  [IN_WIDTH];
  logic [ADDR_WIDTH-1:0] rd_addr  [OUT_WIDTH];
  logic [CNT_WIDTH-1:0]  add_num;
  logic [CNT_WIDTH:0]    demand;
  logic [CNT_WIDTH-1:0]  iss_ext;
  logic [CNT_WIDTH-1:0]  deq;
  logic [CNT_WIDTH-1:0]  keep;
  logic                  walk;
  logic                  enq;

  // Exclusive prefix popcount: each active lane lands at tail plus the number
  // of active lanes below it, which compacts sparse in_en patterns in order.
  always_comb begin
    add_num  = '0;
    lane_off = '{default: '0};
    wr_addr  = '{default: '0};
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      lane_off[i] = add_num[ADDR_WIDTH-1:0];
      wr_addr[i]  = tail_q + add_num[ADDR_WIDTH-1:0];
      add_num     = add_num + CNT_WIDTH'(in_en[i]);
    end
  end

  // full is judged against pre-dequeue occupancy, so a same-cycle pop never
  // makes room for that cycle's enqueue
  assign demand  = {1'b0, num_q} + {1'b0, add_num};
  assign full    = demand > (CNT_WIDTH + 1)'(DEPTH);
  assign iss_ext = CNT_WIDTH'(issue_num);
  assign deq     = (iss_ext > num_q) ? num_q : iss_ext;
  assign enq     = ~dis_full & ~full & ~walk;

  if (NEED_WALK != 0) begin : g_walk
    logic [DEPTH*ROB_W-1:0] rob_flat;

    always_comb begin
      rob_flat = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        rob_flat[e*ROB_W +: ROB_W] = rob_mem_q[e];
      end
    end

    dq_age_mask #(
      .DEPTH        (DEPTH),
      .ROB_IDX_WIDTH(ROB_IDX_WIDTH)
    ) u_age_mask (
      .head            (head_q),
      .num             (num_q),
      .entry_rob_idx   (rob_flat),
      .redirect_rob_idx(redirect_robIdx),
      .keep            (keep)
    );

    assign walk = redirect;

    // popped entries must come from the surviving older prefix
    a_deq_le_keep: assert property (@(posedge clk) disable iff (!rst)
                                    walk |-> (deq <= keep));
  end else begin : g_no_walk
    assign walk = 1'b0;
    assign keep = '0;
  end

  always_comb begin
    head_d = head_q + deq[ADDR_WIDTH-1:0];
    tail_d = tail_q;
    num_d  = num_q;
    if (walk) begin
      // survivors are a prefix from head, so the tail snaps back behind them
      tail_d = head_q + keep[ADDR_WIDTH-1:0];
      num_d  = keep - deq;
    end else begin
      tail_d = tail_q + (enq ? add_num[ADDR_WIDTH-1:0] : '0);
      num_d  = num_q + (enq ? add_num : '0) - deq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      num_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      num_q  <= num_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
        if (in_en[i]) begin
          rs1_mem_q[wr_addr[i]]  <= in_rs1[i*PREG_WIDTH +: PREG_WIDTH];
          rs2_mem_q[wr_addr[i]]  <= in_rs2[i*PREG_WIDTH +: PREG_WIDTH];
          rob_mem_q[wr_addr[i]]  <= in_robIdx[i*ROB_W +: ROB_W];
          data_mem_q[wr_addr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    out_valid  = '0;
    out_rs1    = '0;
    out_rs2    = '0;
    out_robIdx = '0;
    out_data   = '0;
    rd_addr    = '{default: '0};
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      rd_addr[i]                            = head_q + ADDR_WIDTH'(i);
      out_valid[i]                          = num_q > CNT_WIDTH'(i);
      out_rs1[i*PREG_WIDTH +: PREG_WIDTH]   = rs1_mem_q[rd_addr[i]];
      out_rs2[i*PREG_WIDTH +: PREG_WIDTH]   = rs2_mem_q[rd_addr[i]];
      out_robIdx[i*ROB_W +: ROB_W]          = rob_mem_q[rd_addr[i]];
      out_data[i*DATA_WIDTH +: DATA_WIDTH]  = data_mem_q[rd_addr[i]];
    end
  end

  assign count = num_q;

  a_issue_le_num: assert property (@(posedge clk) disable iff (!rst)
                                   iss_ext <= num_q);

endmodule

// File: tb/tb_flex_dispatch_queue.sv
module tb_flex_dispatch_queue;

  localparam int PW = 7;
  localparam int RW = 7;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      in_en = '0;
  logic [4*PW-1:0] in_rs1 = '0;
  logic [4*PW-1:0] in_rs2 = '0;
  logic [4*RW-1:0] in_robIdx = '0;
  logic [4*DW-1:0] in_data = '0;
  logic            dis_full = 1'b0;
  logic            full;
  logic [1:0]      out_valid;
  logic [2*PW-1:0] out_rs1;
  logic [2*PW-1:0] out_rs2;
  logic [2*RW-1:0] out_robIdx;
  logic [2*DW-1:0] out_data;
  logic [1:0]      issue_num = '0;
  logic            redirect = 1'b0;
  logic [RW-1:0]   redirect_robIdx = '0;
  logic [3:0]      count;

  flex_dispatch_queue #(
    .DATA_WIDTH   (32),
    .DEPTH        (8),
    .IN_WIDTH     (4),
    .OUT_WIDTH    (2),
    .PREG_WIDTH   (7),
    .ROB_IDX_WIDTH(6),
    .NEED_WALK    (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_en          (in_en),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_robIdx      (in_robIdx),
    .in_data        (in_data),
    .dis_full       (dis_full),
    .full           (full),
    .out_valid      (out_valid),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_robIdx     (out_robIdx),
    .out_data       (out_data),
    .issue_num      (issue_num),
    .redirect       (redirect),
    .redirect_robIdx(redirect_robIdx),
    .count          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    logic [3:0] cnt;
    logic [1:0] val;
    logic       fl;
  } status_t;

  status_t     status_q[$];
  logic [6:0]  data_q[$];
  int          cyc = 0;
  int          step_no = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pdata(input logic [6:0] r);
    return {r, 8'h3C, r, 3'b101, r};
  endfunction
  function automatic logic [6:0] prs1(input logic [6:0] r);
    return r ^ 7'h2A;
  endfunction
  function automatic logic [6:0] prs2(input logic [6:0] r);
    return ~r;
  endfunction

  task automatic chk(input string what, input int stp, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", what, stp, act, exp);
    end
  endtask

  // Driver: inputs change 1ns after the rising edge; the status expectation
  // describes what the DUT shows during this same cycle.
  task automatic step(input logic rst_v, input logic [3:0] en,
                      input logic [6:0] r3, r2, r1, r0,
                      input logic [1:0] iss, input logic dfull,
                      input logic red, input logic [6:0] rrob,
                      input int sq, input logic x_enq,
                      input logic [3:0] x_cnt, input logic [1:0] x_val, input logic x_fl);
    logic [6:0] rl [4];
    status_t    s;
    @(posedge clk);
    #1;
    rl[0] = r0; rl[1] = r1; rl[2] = r2; rl[3] = r3;
    rst = rst_v;
    in_en = en;
    issue_num = iss;
    dis_full = dfull;
    redirect = red;
    redirect_robIdx = rrob;
    for (int i = 0; i < 4; i++) begin
      in_robIdx[i*RW +: RW] = rl[i];
      in_rs1[i*PW +: PW]    = prs1(rl[i]);
      in_rs2[i*PW +: PW]    = prs2(rl[i]);
      in_data[i*DW +: DW]   = pdata(rl[i]);
    end
    step_no++;
    s.cyc = cyc;
    s.id  = step_no;
    s.cnt = x_cnt;
    s.val = x_val;
    s.fl  = x_fl;
    status_q.push_back(s);
    if (!rst_v) data_q.delete();
    if (x_enq) begin
      for (int i = 0; i < 4; i++) begin
        if (en[i]) data_q.push_back(rl[i]);
      end
    end
    for (int k = 0; k < sq; k++) void'(data_q.pop_back());
  endtask

  // Monitor: mid-cycle, checks the scheduled status and every entry the
  // consumer takes against the front of the expected-entry queue.
  initial begin
    status_t    s;
    logic [6:0] r;
    forever begin
      @(negedge clk);
      while (status_q.size() > 0 && status_q[0].cyc < cyc) begin
        s = status_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL status_unchecked step %0d: got cycle %0d want cycle %0d", s.id, cyc, s.cyc);
      end
      if (status_q.size() > 0 && status_q[0].cyc == cyc) begin
        s = status_q.pop_front();
        chk("count", s.id, 64'(count), 64'(s.cnt));
        chk("out_valid", s.id, 64'(out_valid), 64'(s.val));
        chk("full", s.id, 64'(full), 64'(s.fl));
      end
      for (int i = 0; i < 2; i++) begin
        if (int'(issue_num) > i && out_valid[i] === 1'b1) begin
          if (data_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_extra step %0d: got lane %0d valid want no entry", step_no, i);
          end else begin
            r = data_q.pop_front();
            chk("pop_rob", step_no, 64'(out_robIdx[i*RW +: RW]), 64'(r));
            chk("pop_data", step_no, 64'(out_data[i*DW +: DW]), 64'(pdata(r)));
            chk("pop_rs1", step_no, 64'(out_rs1[i*PW +: PW]), 64'(prs1(r)));
            chk("pop_rs2", step_no, 64'(out_rs2[i*PW +: PW]), 64'(prs2(r)));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus want finish");
    $fatal(1);
  end

  initial begin
    // rst v, en, r3 r2 r1 r0, iss, dfull, red, rrob, squash, enq, count, valid, full
    step(0, 4'hF, 7'h70, 7'h71, 7'h72, 7'h73, 0, 0, 0, 7'h00, 0, 0, 0, 2'b00, 0);
    step(0, 4'hF, 7'h70, 7'h71, 7'h72, 7'h73, 0, 0, 0, 7'h00, 0, 0, 0, 2'b00, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0, 2'b00, 0);
    // sparse lanes 1 and 3
    step(1, 4'b1010, 7'h03, 7'h00, 7'h01, 7'h00, 0, 0, 0, 7'h00, 0, 1, 0, 2'b00, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 2, 0, 0, 7'h00, 0, 0, 2, 2'b11, 0);
    // fill to 6, reject 3 more, accept 2 to reach 8
    step(1, 4'hF, 7'h13, 7'h12, 7'h11, 7'h10, 0, 0, 0, 7'h00, 0, 1, 0, 2'b00, 0);
    step(1, 4'b0011, 7'h00, 7'h00, 7'h15, 7'h14, 0, 0, 0, 7'h00, 0, 1, 4, 2'b11, 0);
    step(1, 4'b0111, 7'h00, 7'h18, 7'h17, 7'h16, 0, 0, 0, 7'h00, 0, 0, 6, 2'b11, 1);
    step(1, 4'b0011, 7'h00, 7'h00, 7'h17, 7'h16, 0, 0, 0, 7'h00, 0, 1, 6, 2'b11, 0);
    step(1, 4'b0001, 7'h00, 7'h00, 7'h00, 7'h18, 0, 0, 0, 7'h00, 0, 0, 8, 2'b11, 1);
    // full while popping: pre-dequeue occupancy still blocks the write
    step(1, 4'b0001, 7'h00, 7'h00, 7'h00, 7'h1F, 1, 0, 0, 7'h00, 0, 0, 8, 2'b11, 1);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 1, 0, 0, 7'h00, 0, 0, 7, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 1, 0, 0, 7'h00, 0, 0, 6, 2'b11, 0);
    // refill across the wrap point, then drain in order
    step(1, 4'b0111, 7'h00, 7'h1A, 7'h19, 7'h18, 0, 0, 0, 7'h00, 0, 1, 5, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 2, 0, 0, 7'h00, 0, 0, 8, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 2, 0, 0, 7'h00, 0, 0, 6, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 2, 0, 0, 7'h00, 0, 0, 4, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 2, 0, 0, 7'h00, 0, 0, 2, 2'b11, 0);
    // redirect at {0,6}: {0,5},{0,6} stay, {0,7},{1,0} squashed, enqueue dropped
    step(1, 4'hF, 7'h40, 7'h07, 7'h06, 7'h05, 0, 0, 0, 7'h00, 0, 1, 0, 2'b00, 0);
    step(1, 4'b0011, 7'h00, 7'h00, 7'h42, 7'h41, 1, 0, 1, 7'h06, 2, 0, 4, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 1, 0, 0, 7'h00, 0, 0, 1, 2'b01, 0);
    // redirect at {1,1}: {0,62} is older across the dir flip, {1,2},{1,3} go
    step(1, 4'b0111, 7'h00, 7'h43, 7'h42, 7'h3E, 0, 0, 0, 7'h00, 0, 1, 0, 2'b00, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0, 1, 7'h41, 2, 0, 3, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 1, 0, 0, 7'h00, 0, 0, 1, 2'b01, 0);
    // dis_full blocks the write while two are issued
    step(1, 4'b0111, 7'h00, 7'h46, 7'h45, 7'h44, 0, 0, 0, 7'h00, 0, 1, 0, 2'b00, 0);
    step(1, 4'hF, 7'h53, 7'h52, 7'h51, 7'h50, 2, 1, 0, 7'h00, 0, 0, 3, 2'b11, 0);
    // same-cycle enqueue and dequeue
    step(1, 4'b0001, 7'h00, 7'h00, 7'h00, 7'h47, 1, 0, 0, 7'h00, 0, 1, 1, 2'b01, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 1, 2'b01, 0);
    // asynchronous reset mid-operation clears before the next edge
    step(0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0, 2'b00, 0);
    step(1, 4'b0011, 7'h00, 7'h00, 7'h61, 7'h60, 0, 0, 0, 7'h00, 0, 1, 0, 2'b00, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 2, 0, 0, 7'h00, 0, 0, 2, 2'b11, 0);
    step(1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0, 2'b00, 0);
    repeat (2) @(negedge clk);
    chk("status_left", step_no, 64'(status_q.size()), 64'd0);
    chk("entries_left", step_no, 64'(data_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
